// File: rtl/bcd_to_binary_encoder.sv
// bcd_to_binary_encoder
// Sequential reverse double-dabble converter: three BCD digits (0-999) in,
// 10-bit binary out. Uses a start/busy/done handshake and flags any digit
// above 9 as an error without running a conversion.
module bcd_to_binary_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [9:0] binary_out,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] bcd_sr;
  logic [11:0] bin_sr;
  logic [3:0]  cnt;

  logic [23:0] shifted;
  logic [11:0] bcd_next;
  logic [11:0] bin_next;
  logic        digit_bad;

  assign digit_bad = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);

  // One reverse double-dabble step: shift right, then pull each BCD nibble
  // that reached 8 or more back down by 3.
  always_comb begin
    shifted  = {bcd_sr, bin_sr} >> 1;
    bin_next = shifted[11:0];
    bcd_next = shifted[23:12];
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd_next[i*4 +: 4] >= 4'd8) begin
        bcd_next[i*4 +: 4] = bcd_next[i*4 +: 4] - 4'd3;
      end
    end
  end

  // Control FSM with registered handshake outputs and the shift registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bcd_sr     <= '0;
      bin_sr     <= '0;
      cnt        <= '0;
      binary_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (digit_bad) begin
              error      <= 1'b1;
              binary_out <= '0;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              bcd_sr <= {hundreds, tens, ones};
              bin_sr <= '0;
              cnt    <= '0;
              error  <= 1'b0;
              busy   <= 1'b1;
              state  <= CONVERT;
            end
          end
        end
        CONVERT: begin
          bcd_sr <= bcd_next;
          bin_sr <= bin_next;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd11) begin
            binary_out <= bin_next[9:0];
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_encoder.sv
// tb_bcd_to_binary_encoder
// Directed and swept stimulus for the BCD-to-binary converter. Expected
// {error, value} pairs are queued when a request is issued and checked when
// done pulses; latency and busy length are checked per request.
module tb_bcd_to_binary_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [9:0] binary_out;
  logic       busy;
  logic       done;
  logic       error;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int exp_dones   = 0;
  logic [10:0] sb[$];

  bcd_to_binary_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .binary_out(binary_out),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest queued request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      logic [10:0] e;
      done_cnt++;
      check("done_with_busy", int'(busy), 0);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("binary_out", int'(binary_out), int'(e[9:0]));
        check("error", int'(error), int'(e[10]));
      end
    end
  end

  // Issue one request; optionally pulse start again (1/1/1) at cycles k+3
  // and k+12 to show it is ignored while a conversion is running.
  task automatic convert(input logic [3:0] h, input logic [3:0] t,
                         input logic [3:0] o, input bit repulse);
    bit valid;
    int exp_val;
    int lat;
    int busy_cnt;
    valid   = (h <= 9) && (t <= 9) && (o <= 9);
    exp_val = valid ? (int'(h) * 100 + int'(t) * 10 + int'(o)) : 0;
    sb.push_back({~valid, 10'(exp_val)});
    exp_dones++;
    @(negedge clk);
    start = 1'b1; hundreds = h; tens = t; ones = o;
    lat = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      start    = (repulse && (lat == 3 || lat == 12)) ? 1'b1 : 1'b0;
      hundreds = repulse ? 4'd1 : 4'($urandom_range(0, 15));
      tens     = repulse ? 4'd1 : 4'($urandom_range(0, 15));
      ones     = repulse ? 4'd1 : 4'($urandom_range(0, 15));
      if (busy) busy_cnt++;
    end while (!done && lat < 40);
    start = 1'b0;
    check("latency", lat, valid ? 13 : 1);
    check("busy_cycles", busy_cnt, valid ? 12 : 0);
  endtask

  initial begin
    int idx;
    rst_n = 1'b0; start = 1'b0; hundreds = '0; tens = '0; ones = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_binary_out", int'(binary_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    rst_n = 1'b1;

    convert(4'd3, 4'd0, 4'd0, 1'b0);
    convert(4'd9, 4'd9, 4'd9, 1'b0);
    convert(4'd0, 4'd0, 4'd0, 1'b0);
    convert(4'd1, 4'd10, 4'd5, 1'b0);
    check("error_persists", int'(error), 1);
    convert(4'd0, 4'd4, 4'd7, 1'b0);
    convert(4'd15, 4'd0, 4'd0, 1'b0);
    convert(4'd2, 4'd5, 4'd6, 1'b1);
    repeat (20) @(negedge clk);
    check("no_extra_done", done_cnt, exp_dones);

    // Reset in the middle of a conversion must abort it silently.
    @(negedge clk);
    start = 1'b1; hundreds = 4'd1; tens = 4'd2; ones = 4'd3;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_binary_out", int'(binary_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_error", int'(error), 0);
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt, exp_dones);
    convert(4'd1, 4'd2, 4'd3, 1'b0);

    // Every valid code, visited in a scrambled order.
    for (int i = 0; i < 1000; i++) begin
      idx = (i * 337 + 211) % 1000;
      convert(4'(idx / 100), 4'((idx / 10) % 10), 4'(idx % 10), 1'b0);
    end

    repeat (5) @(negedge clk);
    check("done_count", done_cnt, exp_dones);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_encoder.md
Name: bcd_to_binary_encoder

Overview:
- Sequential reverse double-dabble converter: 3-digit BCD score (hundreds/tens/ones, 0-999) in, 10-bit binary out.
- Pairs with the existing binary-to-BCD display decoder. Used where BCD-entered values (manual score correction, pin-count keypad) must rejoin the binary scoring datapath.
- Start/busy/done handshake.
- Invalid-digit detection.

Parameters:
- None. Widths are fixed: 3 BCD digits (12 bits) in, 10-bit result out.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  conversion request; accepted only in IDLE
- hundreds  input  4  BCD hundreds digit, sampled on the accepting edge
- tens  input  4  BCD tens digit, sampled on the accepting edge
- ones  input  4  BCD ones digit, sampled on the accepting edge
- binary_out  output  10  converted value; holds until the next done
- busy  output  1  high while a conversion is in progress
- done  output  1  single-cycle pulse; binary_out/error valid in that cycle
- error  output  1  high if the last accepted request had a digit > 9

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, binary_out=0, busy=0, done=0, error=0, internal registers cleared. Reset mid-conversion aborts with no done pulse.
- States: IDLE, CONVERT, DONE.
- IDLE: start=0 -> stay in IDLE.
- IDLE, start=1 at edge k, all digits <= 9:
  - load bcd_sr={hundreds,tens,ones} (12 bits) and bin_sr=12'd0;
  - cnt=0, error<=0, busy<=1, go to CONVERT.
- IDLE, start=1 at edge k, any digit > 9:
  - no conversion; error<=1, binary_out<=0, go to DONE;
  - busy stays 0; done is high in cycle k+1.
- CONVERT, each edge:
  - shift {bcd_sr,bin_sr} right 1 (bcd_sr[0] enters bin_sr[11]);
  - then for each of the 3 nibbles of the shifted bcd_sr: if nibble >= 8, subtract 3;
  - shift and correction occur in the same cycle;
  - cnt increments.
- At the edge where cnt==11 (12th shift, edge k+12): binary_out<=bin_sr_next[9:0], busy<=0, go to DONE.
- DONE: done=1 for exactly one cycle (cycle k+13 for a valid request); next edge goes to IDLE.
- Latency: valid request accepted at edge k -> done in cycle k+13. Back-to-back: the next start is accepted at the edge ending the DONE cycle? No: start is only accepted from IDLE, so throughput is one conversion per 14 cycles.
- Result width: bin_sr[11:10] is always 0 for digits <= 9 (max 999 < 1024). Only [9:0] drives the output.
- start in CONVERT or DONE: ignored, no queuing, inputs not resampled.
- Digit inputs may change freely after the accepting edge.
- binary_out changes only on a done cycle, or on reset. Error cycles set it to 0.
- error persists until the next accepted start.
- done and busy are never high together.

Test Plan:
- Reset, then start with digits 3/0/0 -> done 13 cycles after the accepting edge; binary_out=300 (0x12C), error=0; busy high for exactly 12 cycles.
- Digits 9/9/9 -> binary_out=999 (0x3E7). Digits 0/0/0 -> binary_out=0, done still pulses at k+13.
- Digits 1/10/5 (tens=0xA) -> done at k+1, error=1, binary_out=0, busy never high. A following valid 0/4/7 -> error=0, binary_out=47.
- Start 2/5/6 and pulse start again with 1/1/1 at cycles k+3 and k+12 -> only one done; binary_out=256; inputs changed mid-conversion have no effect.
- Start 1/2/3; drive rst_n=0 at cycle k+6 for one edge -> no done pulse; all outputs 0 after reset. Subsequent start 1/2/3 -> binary_out=123.
- Random sweep of all 1000 valid codes against a reference model -> every result exact; done count equals start count.
